// File: rtl/icache_sa_pkg.sv
// Shared types, constants and width helpers for the set-associative instruction cache.
package icache_sa_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StResp
    } icache_state_e;

    localparam logic [31:0] NULL32 = 32'h0000_0000;
    localparam logic        TRUE   = 1'b1;
    localparam logic        FALSE  = 1'b0;

    function automatic int unsigned calc_tag_w(input int unsigned addr_w,
                                               input int unsigned set_bits,
                                               input int unsigned word_bits);
        return addr_w - set_bits - word_bits - 2;
    endfunction

    function automatic int unsigned calc_line_words(input int unsigned word_bits);
        return 32'd1 << word_bits;
    endfunction

endpackage

// File: rtl/icache_way_mem.sv
// One way of the instruction cache: per-set tag and valid bit plus a word-addressed data array.
// Reads are combinational; writes and the valid clear-all take effect on the clock edge.
module icache_way_mem
    import icache_sa_pkg::*;
#(
    parameter int unsigned SET_BITS  = 4,
    parameter int unsigned WORD_BITS = 2,
    parameter int unsigned TAG_W     = 26
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 data_we,
    input  logic [SET_BITS-1:0]  wr_index,
    input  logic [WORD_BITS-1:0] wr_offset,
    input  logic [31:0]          wr_data,
    input  logic                 tag_we,
    input  logic [TAG_W-1:0]     wr_tag,
    input  logic [SET_BITS-1:0]  rd_index,
    input  logic [WORD_BITS-1:0] rd_offset,
    output logic                 rd_valid,
    output logic [TAG_W-1:0]     rd_tag,
    output logic [31:0]          rd_data
);

    localparam int unsigned SETS  = 32'd1 << SET_BITS;
    localparam int unsigned WORDS = SETS * calc_line_words(WORD_BITS);

    logic [31:0]      data_q [WORDS];
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [SETS-1:0]  valid_q, valid_d;

    always_comb begin
        valid_d = valid_q;
        if (clear) begin
            valid_d = '0;
        end else if (tag_we) begin
            valid_d[wr_index] = TRUE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data and tag arrays carry no reset; valid_q alone qualifies them.
    always_ff @(posedge clk) begin
        if (data_we) begin
            data_q[{wr_index, wr_offset}] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_index] <= wr_tag;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[{rd_index, rd_offset}];

endmodule

// File: rtl/icache_sa.sv
// N-way (1 or 2) set-associative instruction cache with line refill FSM and per-set LRU.
// Optional macro ICACHE_PERF_EN adds saturating hit/miss counter ports.
module icache_sa
    import icache_sa_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned SET_BITS  = 4,
    parameter int unsigned WORD_BITS = 2,
    parameter int unsigned WAYS      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              if_enable,
    input  logic [ADDR_W-1:0] require_addr,
    output logic [31:0]       IF_instr,
    output logic              fetch_success,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable,
    input  logic [31:0]       mem_instr,
    input  logic              mem_fetch_success
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
`endif
);

    localparam int unsigned TAG_W  = calc_tag_w(ADDR_W, SET_BITS, WORD_BITS);
    localparam int unsigned LINE_W = ADDR_W - WORD_BITS - 2;
    localparam int unsigned WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned SETS   = 32'd1 << SET_BITS;

    if (WAYS != 1 && WAYS != 2) begin : g_bad_ways
        $error("icache_sa: WAYS must be 1 or 2");
    end

    icache_state_e state_q, state_d;

    logic [WORD_BITS-1:0] beat_q, beat_d, beat_nxt;
    logic [LINE_W-1:0]    line_q, line_d;
    logic [WAY_W-1:0]     victim_q, victim_d;
    logic                 fetch_success_q, fetch_success_d;
    logic [31:0]          if_instr_q, if_instr_d;
    logic                 mem_enable_q, mem_enable_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;

    logic [WORD_BITS-1:0] req_offset;
    logic [SET_BITS-1:0]  req_index;
    logic [TAG_W-1:0]     req_tag;
    logic [LINE_W-1:0]    req_line;
    logic                 unused_addr;

    assign req_offset  = require_addr[2 +: WORD_BITS];
    assign req_index   = require_addr[WORD_BITS+2 +: SET_BITS];
    assign req_tag     = require_addr[ADDR_W-1 -: TAG_W];
    assign req_line    = require_addr[ADDR_W-1:WORD_BITS+2];
    assign unused_addr = ^require_addr[1:0];

    logic [WAYS-1:0]  way_valid, hit_vec;
    logic [TAG_W-1:0] way_tag  [WAYS];
    logic [31:0]      way_data [WAYS];

    logic data_we, tag_we, flush_act;
    logic lru_we;
    logic [SET_BITS-1:0] lru_set;
    logic [WAY_W-1:0]    lru_mru, lru_way;

    assign flush_act = flush && rdy;

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        icache_way_mem #(
            .SET_BITS (SET_BITS),
            .WORD_BITS(WORD_BITS),
            .TAG_W    (TAG_W)
        ) u_way_mem (
            .clk      (clk),
            .rst      (rst),
            .clear    (flush_act),
            .data_we  (data_we && rdy && (victim_q == WAY_W'(w))),
            .wr_index (line_q[SET_BITS-1:0]),
            .wr_offset(beat_q),
            .wr_data  (mem_instr),
            .tag_we   (tag_we && rdy && (victim_q == WAY_W'(w))),
            .wr_tag   (line_q[LINE_W-1:SET_BITS]),
            .rd_index (req_index),
            .rd_offset(req_offset),
            .rd_valid (way_valid[w]),
            .rd_tag   (way_tag[w]),
            .rd_data  (way_data[w])
        );
        assign hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
    end

    // LRU bit per set names the least-recently-used way.
    if (WAYS == 2) begin : g_lru
        logic [SETS-1:0] lru_q, lru_d;

        always_comb begin
            lru_d = lru_q;
            if (lru_we) begin
                lru_d[lru_set] = ~lru_mru;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                lru_q <= '0;
            end else if (rdy) begin
                lru_q <= lru_d;
            end
        end

        assign lru_way = lru_q[req_index];
    end else begin : g_no_lru
        logic unused_lru;
        assign unused_lru = ^{lru_we, lru_set, lru_mru};
        assign lru_way    = '0;
    end

    logic             hit;
    logic [WAY_W-1:0] hit_way, victim;
    logic [31:0]      hit_data;

    always_comb begin
        hit_way  = '0;
        hit_data = way_data[0];
        for (int w = 0; w < WAYS; w++) begin
            if (hit_vec[w]) begin
                hit_way  = WAY_W'(w);
                hit_data = way_data[w];
            end
        end
        victim = lru_way;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!way_valid[w]) begin
                victim = WAY_W'(w);
            end
        end
    end

    assign hit = |hit_vec;

    // The cycle that carries a fetch_success pulse never looks up, so a held request
    // is served at most once per two cycles.
    logic lookup, idle_hit, idle_miss, refill_done, resp_match;

    assign lookup      = (state_q == StIdle) && if_enable && !fetch_success_q && !flush;
    assign idle_hit    = lookup && hit;
    assign idle_miss   = lookup && !hit;
    assign refill_done = (state_q == StRefill) && mem_fetch_success && !flush
                         && (beat_q == {WORD_BITS{1'b1}});
    assign resp_match  = if_enable && (req_line == line_q);
    assign beat_nxt    = beat_q + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else if (rdy) begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:   if (idle_miss) state_d = StRefill;
                StRefill: if (refill_done) state_d = StResp;
                StResp:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        beat_d          = beat_q;
        line_d          = line_q;
        victim_d        = victim_q;
        fetch_success_d = FALSE;
        if_instr_d      = if_instr_q;
        mem_enable_d    = mem_enable_q;
        mem_addr_d      = mem_addr_q;
        data_we         = FALSE;
        tag_we          = FALSE;
        lru_we          = FALSE;
        lru_set         = req_index;
        lru_mru         = hit_way;
        if (flush) begin
            mem_enable_d = FALSE;
            beat_d       = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (idle_hit) begin
                        fetch_success_d = TRUE;
                        if_instr_d      = hit_data;
                        lru_we          = TRUE;
                    end else if (idle_miss) begin
                        line_d       = req_line;
                        victim_d     = victim;
                        beat_d       = '0;
                        mem_enable_d = TRUE;
                        mem_addr_d   = {req_line, {WORD_BITS{1'b0}}, 2'b00};
                    end
                end
                StRefill: begin
                    if (mem_fetch_success) begin
                        data_we = TRUE;
                        if (refill_done) begin
                            tag_we       = TRUE;
                            mem_enable_d = FALSE;
                            lru_we       = TRUE;
                            lru_set      = line_q[SET_BITS-1:0];
                            lru_mru      = victim_q;
                            beat_d       = '0;
                        end else begin
                            beat_d     = beat_nxt;
                            mem_addr_d = {line_q, beat_nxt, 2'b00};
                        end
                    end
                end
                StResp: begin
                    if (resp_match) begin
                        fetch_success_d = TRUE;
                        if_instr_d      = way_data[victim_q];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q          <= '0;
            line_q          <= '0;
            victim_q        <= '0;
            fetch_success_q <= FALSE;
            if_instr_q      <= NULL32;
            mem_enable_q    <= FALSE;
            mem_addr_q      <= '0;
        end else if (rdy) begin
            beat_q          <= beat_d;
            line_q          <= line_d;
            victim_q        <= victim_d;
            fetch_success_q <= fetch_success_d;
            if_instr_q      <= if_instr_d;
            mem_enable_q    <= mem_enable_d;
            mem_addr_q      <= mem_addr_d;
        end
    end

    assign IF_instr      = if_instr_q;
    assign fetch_success = fetch_success_q;
    assign mem_enable    = mem_enable_q;
    assign mem_addr      = mem_addr_q;

`ifdef ICACHE_PERF_EN
    logic [31:0] perf_hits_q, perf_hits_d, perf_misses_q, perf_misses_d;

    always_comb begin
        perf_hits_d   = perf_hits_q;
        perf_misses_d = perf_misses_q;
        if (idle_hit && perf_hits_q != 32'hFFFF_FFFF) begin
            perf_hits_d = perf_hits_q + 32'd1;
        end
        if (idle_miss && perf_misses_q != 32'hFFFF_FFFF) begin
            perf_misses_d = perf_misses_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_hits_q   <= NULL32;
            perf_misses_q <= NULL32;
        end else if (rdy) begin
            perf_hits_q   <= perf_hits_d;
            perf_misses_q <= perf_misses_d;
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised successor to the direct-mapped, single-word instruction cache.
- N-way set-associative with multi-word lines and a line-refill FSM toward mem_ctrl. Per-set LRU replacement. Flush/invalidate input.
- Sits between the IF stage and mem_ctrl: serves IF fetches by PC and refills a full line word-by-word on a miss.

Parameters:
- ADDR_W, 32, address width (byte address).
- SET_BITS, 4, log2 number of sets (16 sets).
- WORD_BITS, 2, log2 words per line (4 words = 16 B).
- WAYS, 2, associativity; legal values 1 or 2 only; anything else is a compile-time error.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rdy  in  1  global ready; low freezes all state and outputs
- flush  in  1  invalidate all lines; abort any refill
- if_enable  in  1  IF fetch request, held until fetch_success
- require_addr  in  ADDR_W  fetch PC; bits [1:0] ignored
- IF_instr  out  32  fetched instruction
- fetch_success  out  1  one-cycle pulse: IF_instr valid for require_addr
- mem_addr  out  ADDR_W  word address of current refill beat
- mem_enable  out  1  refill beat request, held until mem_fetch_success
- mem_instr  in  32  word returned by mem_ctrl
- mem_fetch_success  in  1  one-cycle pulse: mem_instr valid for mem_addr

Behaviour:
- Reset is asynchronous and active-high:
  - Outputs: fetch_success=0, mem_enable=0, mem_addr=0, IF_instr=0.
  - State: all valid bits=0, all LRU bits=0, FSM=IDLE.
- Address split:
  - offset = addr[WORD_BITS+1:2]
  - index = addr[SET_BITS+WORD_BITS+1:WORD_BITS+2]
  - tag = remaining upper bits
- IDLE state (if_enable=1, rdy=1, flush=0):
  - Hit in any way: next cycle IF_instr=word, fetch_success=1. LRU of the set marks the hit way as most-recent.
  - fetch_success is a single-cycle pulse. A request still held after the pulse is looked up again (back-to-back hits give one result per 2 cycles minimum).
  - Miss: latch the line base address and victim way, go to REFILL.
  - Victim way = first invalid way, else the LRU way.
- REFILL state:
  - mem_enable=1, mem_addr = line base + 4*beat. beat counts 0..2^WORD_BITS-1, starting at word 0.
  - On each mem_fetch_success, write mem_instr into the victim data at that beat and advance beat.
  - mem_addr updates in the same cycle the pulse is seen; mem_enable stays high between beats.
  - After the last beat: mem_enable=0, write tag, set valid, update LRU, go to RESP.
- RESP state: the requested word is driven from the refilled line, fetch_success=1 for one cycle, then IDLE.
  - Miss latency: refill beats + 2 cycles.
- Boundary and concurrency rules:
  - if_enable dropped or require_addr changed mid-refill: the refill completes and the line is installed. RESP is suppressed if the held request no longer matches the latched line address; IDLE then re-looks up.
  - flush in any state: all valid bits cleared next cycle, mem_enable=0, FSM=IDLE, no fetch_success.
    - A mem_fetch_success arriving in the same cycle is discarded and the partial line is not validated.
  - flush has priority over a hit in the same cycle.
  - rdy=0: hold FSM, beat, outputs. A mem_fetch_success during rdy=0 is the mem_ctrl's responsibility (it is gated by the same rdy).
  - WAYS=1: LRU storage omitted; victim is always way 0.
  - Beat counter wraps only via FSM exit; never overruns the line.

Optional Feature:
- Macro ICACHE_PERF_EN.
- When defined, adds two ports, perf_hits and perf_misses (out, 32 each). These are saturating counters:
  - perf_hits increments on each IDLE hit.
  - perf_misses increments on each IDLE-to-REFILL transition.
  - Reset to 0 by rst; unaffected by flush.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package/define.v:
  - ICACHE state encoding (IDLE/REFILL/RESP).
  - Derived widths TAG_W, LINE_WORDS.
  - NULL32, TRUE/FALSE.
- Sub-module icache_way_mem: one way's data/tag/valid storage.
  - Parametrised by SET_BITS/WORD_BITS.
  - Combinational read, synchronous write, valid clear-all on flush/rst.
  - Instantiated WAYS times.
- FSM, LRU and hit-select logic live in icache_sa.

Test Plan:
1. Cold miss: rst, then fetch 0x0000_1004. Expect:
   - mem_addr 0x1000, 0x1004, 0x1008, 0x100C with mem_enable held.
   - mem returns 0xA0..0xA3, then fetch_success with IF_instr=0xA1.
2. Hit after fill: fetch 0x1008 then 0x100C. Each gives fetch_success 1 cycle after request, IF_instr 0xA2/0xA3, no mem_enable.
3. Conflict/LRU (WAYS=2, SET_BITS=4): fill 0x1000 (way0) and 0x2000 (way1); hit 0x1000; miss 0x3000.
   - Expect way1 (0x2000) evicted.
   - 0x1000 still hits; 0x2000 misses.
4. Flush mid-refill: miss 0x4000; flush after 2 beats. Expect:
   - mem_enable=0 next cycle, no fetch_success.
   - Refetch 0x4000 misses again, restarting at 0x4000.
5. Request change mid-refill: miss 0x5000; switch require_addr to 0x1000 after beat 1. Expect:
   - Refill of 0x5000 completes with no RESP pulse.
   - Then fetch_success for 0x1000 only if resident.
   - Later, 0x5000 hits.
6. Async reset mid-refill: assert rst between clock edges. Outputs go 0 immediately; all lines invalid afterwards.
   - With ICACHE_PERF_EN, counters read 0; after scenarios 1–2, hits=2 and misses=1.
